// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: AHB-Lite responder-side interconnect for ROM, SRAM and the
// AHB-to-APB bridge, with a built-in default slave for unmapped addresses.
//
// Ports:
//   clk, reset                     bus clock, synchronous active-high reset
//   HADDR, HTRANS, HWRITE          shared address-phase signals
//   HSEL_ROM/SRAM/APB              combinational address-phase selects
//   HRDATA_*/HREADY_*/HRESP_*      per-slave data-phase responses
//   HRDATA, HREADY, HRESP          muxed data-phase response to the masters
//   err_count, err_addr, err_write default-slave error log
module ahb_slave_mux #(
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int unsigned ROM_SIZE  = 4096,
  parameter logic [31:0] SRAM_BASE = 32'h0001_0000,
  parameter int unsigned SRAM_SIZE = 4096,
  parameter logic [31:0] APB_BASE  = 32'h0020_0000,
  parameter int unsigned APB_SIZE  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  output logic        HSEL_ROM,
  output logic        HSEL_SRAM,
  output logic        HSEL_APB,
  input  logic [31:0] HRDATA_ROM,
  input  logic [31:0] HRDATA_SRAM,
  input  logic [31:0] HRDATA_APB,
  input  logic        HREADY_ROM,
  input  logic        HREADY_SRAM,
  input  logic        HREADY_APB,
  input  logic        HRESP_ROM,
  input  logic        HRESP_SRAM,
  input  logic        HRESP_APB,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [15:0] err_count,
  output logic [31:0] err_addr,
  output logic        err_write
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  localparam logic [AW-1:0] ROM_MASK  = ~(AW'(ROM_SIZE)  - AW'(1));
  localparam logic [AW-1:0] SRAM_MASK = ~(AW'(SRAM_SIZE) - AW'(1));
  localparam logic [AW-1:0] APB_MASK  = ~(AW'(APB_SIZE)  - AW'(1));

  typedef enum logic [2:0] {
    DSEL_NONE, DSEL_ROM, DSEL_SRAM, DSEL_APB, DSEL_DEF
  } dsel_e;

  typedef enum logic [1:0] {
    DS_IDLE, DS_ERR1, DS_ERR2
  } ds_state_e;

  dsel_e          dsel_q, dsel_d;
  ds_state_e      ds_state_q, ds_state_d;
  logic [CW-1:0]  err_count_q, err_count_d;
  logic [AW-1:0]  err_addr_q, err_addr_d;
  logic           err_write_q, err_write_d;

  logic           hit_rom_c, hit_sram_c, hit_apb_c;
  logic           sel_rom_c, sel_sram_c, sel_apb_c;
  logic           unmapped_c;
  logic           accept_c, unmapped_acc_c;
  logic           ds_hready_c, ds_hresp_c;
  logic [AW-1:0]  hrdata_c;
  logic           hready_c, hresp_c;

  // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY, which select identically.
  logic           unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Address decode with ROM > SRAM > APB priority on overlap.
  always_comb begin
    hit_rom_c  = (HADDR & ROM_MASK)  == ROM_BASE;
    hit_sram_c = (HADDR & SRAM_MASK) == SRAM_BASE;
    hit_apb_c  = (HADDR & APB_MASK)  == APB_BASE;
    sel_rom_c  = hit_rom_c;
    sel_sram_c = hit_sram_c & ~hit_rom_c;
    sel_apb_c  = hit_apb_c & ~hit_rom_c & ~hit_sram_c;
    unmapped_c = ~(hit_rom_c | hit_sram_c | hit_apb_c);
  end

  assign HSEL_ROM  = sel_rom_c;
  assign HSEL_SRAM = sel_sram_c;
  assign HSEL_APB  = sel_apb_c;

  // A transfer is accepted when it is active (NONSEQ/SEQ) and the bus is ready.
  assign accept_c       = hready_c & HTRANS[1];
  assign unmapped_acc_c = accept_c & unmapped_c;

  // Data-phase select: only advances on HREADY so a stalled address is ignored.
  always_comb begin
    dsel_d = dsel_q;
    if (hready_c) begin
      if (!HTRANS[1])      dsel_d = DSEL_NONE;
      else if (sel_rom_c)  dsel_d = DSEL_ROM;
      else if (sel_sram_c) dsel_d = DSEL_SRAM;
      else if (sel_apb_c)  dsel_d = DSEL_APB;
      else                 dsel_d = DSEL_DEF;
    end
  end

  // Default-slave FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) ds_state_q <= DS_IDLE;
    else       ds_state_q <= ds_state_d;
  end

  // Default-slave FSM: next state.
  always_comb begin
    ds_state_d = ds_state_q;
    case (ds_state_q)
      DS_IDLE: if (unmapped_acc_c) ds_state_d = DS_ERR1;
      DS_ERR1: ds_state_d = DS_ERR2;
      DS_ERR2: ds_state_d = unmapped_acc_c ? DS_ERR1 : DS_IDLE;
      default: ds_state_d = DS_IDLE;
    endcase
  end

  // Default-slave FSM: two-cycle ERROR response outputs.
  always_comb begin
    ds_hready_c = 1'b1;
    ds_hresp_c  = 1'b0;
    case (ds_state_q)
      DS_ERR1: begin
        ds_hready_c = 1'b0;
        ds_hresp_c  = 1'b1;
      end
      DS_ERR2: begin
        ds_hready_c = 1'b1;
        ds_hresp_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Response mux driven by the registered data-phase select.
  always_comb begin
    hrdata_c = '0;
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    case (dsel_q)
      DSEL_ROM: begin
        hrdata_c = HRDATA_ROM;
        hready_c = HREADY_ROM;
        hresp_c  = HRESP_ROM;
      end
      DSEL_SRAM: begin
        hrdata_c = HRDATA_SRAM;
        hready_c = HREADY_SRAM;
        hresp_c  = HRESP_SRAM;
      end
      DSEL_APB: begin
        hrdata_c = HRDATA_APB;
        hready_c = HREADY_APB;
        hresp_c  = HRESP_APB;
      end
      DSEL_DEF: begin
        hready_c = ds_hready_c;
        hresp_c  = ds_hresp_c;
      end
      default: ;
    endcase
  end

  assign HRDATA = hrdata_c;
  assign HREADY = hready_c;
  assign HRESP  = hresp_c;

  // Error log: capture the unmapped transfer, count ERR1 entries with saturation.
  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    if (unmapped_acc_c) begin
      err_addr_d  = HADDR;
      err_write_d = HWRITE;
      if (err_count_q != {CW{1'b1}}) err_count_d = err_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsel_q      <= DSEL_NONE;
      err_count_q <= '0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
    end else begin
      dsel_q      <= dsel_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// tb_ahb_slave_mux: directed bench for ahb_slave_mux. The stimulus process
// pushes the expected per-cycle response into a scoreboard queue; a monitor
// on the falling edge pops and compares against the DUT outputs.
module tb_ahb_slave_mux;

  logic        clk;
  logic        reset;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL_ROM, HSEL_SRAM, HSEL_APB;
  logic [31:0] HRDATA_ROM, HRDATA_SRAM, HRDATA_APB;
  logic        HREADY_ROM, HREADY_SRAM, HREADY_APB;
  logic        HRESP_ROM, HRESP_SRAM, HRESP_APB;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [15:0] err_count;
  logic [31:0] err_addr;
  logic        err_write;

  ahb_slave_mux dut (
    .clk         (clk),
    .reset       (reset),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSEL_ROM    (HSEL_ROM),
    .HSEL_SRAM   (HSEL_SRAM),
    .HSEL_APB    (HSEL_APB),
    .HRDATA_ROM  (HRDATA_ROM),
    .HRDATA_SRAM (HRDATA_SRAM),
    .HRDATA_APB  (HRDATA_APB),
    .HREADY_ROM  (HREADY_ROM),
    .HREADY_SRAM (HREADY_SRAM),
    .HREADY_APB  (HREADY_APB),
    .HRESP_ROM   (HRESP_ROM),
    .HRESP_SRAM  (HRESP_SRAM),
    .HRESP_APB   (HRESP_APB),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .err_count   (err_count),
    .err_addr    (err_addr),
    .err_write   (err_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic [2:0]  sel;    // {rom, sram, apb}
    logic [15:0] cnt;
    logic [31:0] eaddr;
    logic        ewr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_err    = 0;

  // Expected error log, advanced by hand after each accepting edge.
  logic [15:0] e_cnt;
  logic [31:0] e_addr;
  logic        e_wr;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare one scoreboard entry per cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.name, ".hready"},    32'(HREADY), 32'(mon_e.rdy));
      check({mon_e.name, ".hresp"},     32'(HRESP), 32'(mon_e.rsp));
      check({mon_e.name, ".hrdata"},    HRDATA, mon_e.data);
      check({mon_e.name, ".hsel"},      32'({HSEL_ROM, HSEL_SRAM, HSEL_APB}), 32'(mon_e.sel));
      check({mon_e.name, ".err_count"}, 32'(err_count), 32'(mon_e.cnt));
      check({mon_e.name, ".err_addr"},  err_addr, mon_e.eaddr);
      check({mon_e.name, ".err_write"}, 32'(err_write), 32'(mon_e.ewr));
    end
  end

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
    HADDR  = a;
    HTRANS = t;
    HWRITE = w;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic step(input string nm, input logic rdy, input logic rsp,
                      input logic [31:0] data, input logic [2:0] sel);
    exp_t e;
    e.name  = nm;
    e.rdy   = rdy;
    e.rsp   = rsp;
    e.data  = data;
    e.sel   = sel;
    e.cnt   = e_cnt;
    e.eaddr = e_addr;
    e.ewr   = e_wr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(32'h0001_0020, IDLE, 1'b0);
    HRDATA_ROM  = 32'hDEAD_BEEF; HREADY_ROM  = 1'b1; HRESP_ROM  = 1'b0;
    HRDATA_SRAM = 32'h1234_5678; HREADY_SRAM = 1'b1; HRESP_SRAM = 1'b0;
    HRDATA_APB  = 32'h0000_0000; HREADY_APB  = 1'b1; HRESP_APB  = 1'b0;
    e_cnt = 16'd0; e_addr = 32'd0; e_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset; selects follow HADDR.
    step("rst_idle_sram", 1'b1, 1'b0, 32'h0, 3'b010);
    drive(32'h0020_0000, IDLE, 1'b0);
    step("rst_idle_apb", 1'b1, 1'b0, 32'h0, 3'b001);

    // ROM read.
    drive(32'h0000_0010, NONSEQ, 1'b0);
    step("rom_addr", 1'b1, 1'b0, 32'h0, 3'b100);
    drive(32'h0030_0000, IDLE, 1'b0);
    step("rom_data", 1'b1, 1'b0, 32'hDEAD_BEEF, 3'b000);

    // APB read with three wait states; SRAM address held meanwhile.
    drive(32'h0020_0004, NONSEQ, 1'b0);
    HREADY_APB = 1'b0;
    step("apb_addr", 1'b1, 1'b0, 32'h0, 3'b001);
    drive(32'h0001_0004, NONSEQ, 1'b0);
    step("apb_wait1", 1'b0, 1'b0, 32'h0, 3'b010);
    step("apb_wait2", 1'b0, 1'b0, 32'h0, 3'b010);
    step("apb_wait3", 1'b0, 1'b0, 32'h0, 3'b010);
    HREADY_APB = 1'b1;
    HRDATA_APB = 32'h0000_0055;
    step("apb_data", 1'b1, 1'b0, 32'h0000_0055, 3'b010);
    drive(32'h0000_0000, IDLE, 1'b0);
    HRDATA_APB = 32'hAAAA_0000;
    step("sram_data", 1'b1, 1'b0, 32'h1234_5678, 3'b100);

    // Unmapped write: two-cycle ERROR.
    drive(32'h4000_0000, NONSEQ, 1'b1);
    step("unm_addr", 1'b1, 1'b0, 32'h0, 3'b000);
    e_cnt = 16'd1; e_addr = 32'h4000_0000; e_wr = 1'b1;
    drive(32'h0000_0010, IDLE, 1'b0);
    step("unm_err1", 1'b0, 1'b1, 32'h0, 3'b100);
    step("unm_err2", 1'b1, 1'b1, 32'h0, 3'b100);
    step("unm_done", 1'b1, 1'b0, 32'h0, 3'b100);

    // Back-to-back unmapped, second captured in ERR2, then SRAM captured in ERR2.
    drive(32'h5000_0000, NONSEQ, 1'b0);
    step("b2b_addr", 1'b1, 1'b0, 32'h0, 3'b000);
    e_cnt = 16'd2; e_addr = 32'h5000_0000; e_wr = 1'b0;
    drive(32'h6000_0000, NONSEQ, 1'b1);
    step("b2b_err1a", 1'b0, 1'b1, 32'h0, 3'b000);
    step("b2b_err2a", 1'b1, 1'b1, 32'h0, 3'b000);
    e_cnt = 16'd3; e_addr = 32'h6000_0000; e_wr = 1'b1;
    drive(32'h0001_0008, NONSEQ, 1'b0);
    HRDATA_SRAM = 32'hCAFE_F00D;
    step("b2b_err1b", 1'b0, 1'b1, 32'h0, 3'b010);
    step("b2b_err2b", 1'b1, 1'b1, 32'h0, 3'b010);
    drive(32'h0000_0000, IDLE, 1'b0);
    step("b2b_sram", 1'b1, 1'b0, 32'hCAFE_F00D, 3'b100);

    // SRAM's own two-cycle ERROR passes through unmodified.
    drive(32'h0001_000C, NONSEQ, 1'b0);
    step("serr_addr", 1'b1, 1'b0, 32'h0, 3'b010);
    drive(32'h0000_0000, IDLE, 1'b0);
    HREADY_SRAM = 1'b0; HRESP_SRAM = 1'b1; HRDATA_SRAM = 32'h0;
    step("serr_c1", 1'b0, 1'b1, 32'h0, 3'b100);
    HREADY_SRAM = 1'b1;
    step("serr_c2", 1'b1, 1'b1, 32'h0, 3'b100);
    HRESP_SRAM = 1'b0;

    // Reset during ERR1 abandons the error and clears the log.
    drive(32'h7000_0000, NONSEQ, 1'b0);
    step("rerr_addr", 1'b1, 1'b0, 32'h0, 3'b000);
    e_cnt = 16'd4; e_addr = 32'h7000_0000; e_wr = 1'b0;
    drive(32'h0000_0000, IDLE, 1'b0);
    reset = 1'b1;
    step("rerr_err1", 1'b0, 1'b1, 32'h0, 3'b100);
    reset = 1'b0;
    e_cnt = 16'd0; e_addr = 32'd0; e_wr = 1'b0;
    step("rerr_after", 1'b1, 1'b0, 32'h0, 3'b100);

    // Saturation: preload the counter one below the ceiling.
    force dut.err_count_q = 16'hFFFE;
    #2;
    release dut.err_count_q;
    e_cnt = 16'hFFFE;
    drive(32'h8000_0000, NONSEQ, 1'b0);
    step("sat_addr", 1'b1, 1'b0, 32'h0, 3'b000);
    e_cnt = 16'hFFFF; e_addr = 32'h8000_0000; e_wr = 1'b0;
    drive(32'h9000_0000, NONSEQ, 1'b1);
    step("sat_err1a", 1'b0, 1'b1, 32'h0, 3'b000);
    step("sat_err2a", 1'b1, 1'b1, 32'h0, 3'b000);
    e_addr = 32'h9000_0000; e_wr = 1'b1;
    drive(32'h0000_0000, IDLE, 1'b0);
    step("sat_err1b", 1'b0, 1'b1, 32'h0, 3'b100);
    step("sat_err2b", 1'b1, 1'b1, 32'h0, 3'b100);
    step("sat_done", 1'b1, 1'b0, 32'h0, 3'b100);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
